// File: rtl/synapse_ctrl.sv
// Synapse table loader and STDP weight-update sequencer.
// Loads the synapse table at start-up, then serves read-modify-write updates.
module synapse_ctrl #(
    parameter int N_WORDS = 32,
    parameter int RD_LAT  = 2,
    parameter int WR_HOLD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    output logic        load_ready,
    output logic        load_done,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [6:0]  upd_addr,
    input  logic        upd_ltp,
    input  logic [7:0]  upd_delta,
    output logic        upd_done,
    output logic [7:0]  upd_weight,
    output logic        syn_load,
    output logic [15:0] iADDR,
    output logic [31:0] W_DATA,
    output logic        W_EN,
    output logic        R_EN,
    input  logic [7:0]  weight_in,
    output logic        busy
);

    localparam logic [2:0] S_LOAD = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_CALC = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;

    localparam logic [4:0] W_LAST  = 5'(N_WORDS - 1);
    localparam logic [7:0] RD_LAST = 8'(RD_LAT - 1);
    localparam logic [7:0] WR_LAST = 8'(WR_HOLD - 1);

    logic [2:0] state;
    logic       armed;
    logic [4:0] wcnt;
    logic [7:0] cyc;
    logic [6:0] addr_q;
    logic       ltp_q;
    logic [7:0] delta_q;
    logic [7:0] w_q;
    logic [7:0] new_q;
    logic [8:0] sum9;
    logic [8:0] diff9;
    logic [7:0] calc_w;
    logic       beat;
    logic       in_upd;
    logic       in_wr;

    // armed keeps LOAD handshakes quiet until the first edge after reset
    assign syn_load   = (state == S_LOAD) && armed;
    assign load_ready = syn_load;
    assign beat       = syn_load && load_valid;

    assign upd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign R_EN      = (state == S_RD);
    assign in_wr     = (state == S_WR);
    assign W_EN      = beat || in_wr;

    assign in_upd = (state == S_RD) || (state == S_CALC) || in_wr;
    assign iADDR  = in_upd ? {9'b0, addr_q} : 16'b0;

    always_comb begin
        W_DATA = 32'b0;
        if (beat)
            W_DATA = load_data;
        else if (in_wr)
            W_DATA = {24'b0, new_q};
    end

    assign upd_done   = in_wr && (cyc == WR_LAST);
    assign upd_weight = upd_done ? new_q : 8'b0;

    // Saturating add/subtract carried out in 9 bits
    assign sum9   = {1'b0, w_q} + {1'b0, delta_q};
    assign diff9  = {1'b0, w_q} - {1'b0, delta_q};
    assign calc_w = ltp_q ? (sum9[8]  ? 8'hFF : sum9[7:0])
                          : (diff9[8] ? 8'h00 : diff9[7:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_LOAD;
            armed     <= 1'b0;
            wcnt      <= 5'd0;
            cyc       <= 8'd0;
            addr_q    <= 7'd0;
            ltp_q     <= 1'b0;
            delta_q   <= 8'd0;
            w_q       <= 8'd0;
            new_q     <= 8'd0;
            load_done <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                S_LOAD: begin
                    if (beat) begin
                        wcnt <= wcnt + 5'd1;
                        if (wcnt == W_LAST) begin
                            state     <= S_IDLE;
                            load_done <= 1'b1;
                        end
                    end
                end
                S_IDLE: begin
                    if (upd_valid) begin
                        addr_q  <= upd_addr;
                        ltp_q   <= upd_ltp;
                        delta_q <= upd_delta;
                        cyc     <= 8'd0;
                        state   <= S_RD;
                    end
                end
                S_RD: begin
                    if (cyc == RD_LAST) begin
                        w_q   <= weight_in;
                        cyc   <= 8'd0;
                        state <= S_CALC;
                    end else begin
                        cyc <= cyc + 8'd1;
                    end
                end
                S_CALC: begin
                    new_q <= calc_w;
                    state <= S_WR;
                end
                S_WR: begin
                    if (cyc == WR_LAST) begin
                        cyc   <= 8'd0;
                        state <= S_IDLE;
                    end else begin
                        cyc <= cyc + 8'd1;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_synapse_ctrl.sv
// Directed bench for synapse_ctrl: load, saturating updates, handshake
// gating and reset during write-back.
module tb_synapse_ctrl;

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_ready;
    logic        load_done;
    logic        upd_valid;
    logic        upd_ready;
    logic [6:0]  upd_addr;
    logic        upd_ltp;
    logic [7:0]  upd_delta;
    logic        upd_done;
    logic [7:0]  upd_weight;
    logic        syn_load;
    logic [15:0] iADDR;
    logic [31:0] W_DATA;
    logic        W_EN;
    logic        R_EN;
    logic [7:0]  weight_in;
    logic        busy;

    int          n_chk;
    int          n_pass;
    int          wen_cnt;
    bit          loading;
    logic [15:0] cur_addr;

    synapse_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_done  (load_done),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_addr   (upd_addr),
        .upd_ltp    (upd_ltp),
        .upd_delta  (upd_delta),
        .upd_done   (upd_done),
        .upd_weight (upd_weight),
        .syn_load   (syn_load),
        .iADDR      (iADDR),
        .W_DATA     (W_DATA),
        .W_EN       (W_EN),
        .R_EN       (R_EN),
        .weight_in  (weight_in),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("ren_wen_excl", {31'b0, R_EN & W_EN}, 32'd0);
            if (busy && load_done)
                chk("iaddr_stable", {16'b0, iADDR}, {16'b0, cur_addr});
            if (loading && W_EN)
                wen_cnt++;
        end
    end

    task automatic load_table(input bit gaps);
        wen_cnt = 0;
        loading = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (gaps && (i % 3 == 1)) begin
                load_valid = 1'b0;
                #1;
                chk("gap_wen", {31'b0, W_EN}, 32'd0);
                chk("gap_rdy", {31'b0, load_ready}, 32'd1);
                tick();
            end
            load_valid = 1'b1;
            load_data  = 32'hC0DE0000 + 32'(i) * 32'h101;
            #1;
            chk("ld_wen", {31'b0, W_EN}, 32'd1);
            chk("ld_wdata", W_DATA, load_data);
            chk("ld_syn", {31'b0, syn_load}, 32'd1);
            chk("ld_updrdy", {31'b0, upd_ready}, 32'd0);
            chk("ld_done_lo", {31'b0, load_done}, 32'd0);
            tick();
        end
        load_valid = 1'b0;
        loading    = 1'b0;
        #1;
        chk("ld_done", {31'b0, load_done}, 32'd1);
        chk("ld_rdy_off", {31'b0, load_ready}, 32'd0);
        chk("ld_syn_off", {31'b0, syn_load}, 32'd0);
        chk("ld_idle", {31'b0, busy}, 32'd0);
        chk("ld_wen_cnt", 32'(wen_cnt), 32'd32);
    endtask

    task automatic do_update(input logic [6:0] a, input logic l,
                             input logic [7:0] d, input logic [7:0] w,
                             input logic [7:0] e, input bit keep);
        int n;
        cur_addr   = {9'b0, a};
        upd_valid  = 1'b1;
        upd_addr   = a;
        upd_ltp    = l;
        upd_delta  = d;
        weight_in  = 8'h11;
        #1;
        chk("upd_ready", {31'b0, upd_ready}, 32'd1);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        n = 1;
        tick();
        if (!keep) begin
            upd_valid = 1'b0;
            upd_addr  = ~a;
            upd_ltp   = ~l;
            upd_delta = ~d;
        end
        for (int i = 0; i < 2; i++) begin
            weight_in = (i == 1) ? w : ~w;
            #1;
            chk("rd_ren", {31'b0, R_EN}, 32'd1);
            chk("rd_wen", {31'b0, W_EN}, 32'd0);
            chk("rd_addr", {16'b0, iADDR}, {25'b0, a});
            chk("rd_rdy", {31'b0, upd_ready}, 32'd0);
            n++;
            tick();
        end
        weight_in = 8'hEE;
        #1;
        chk("calc_ren", {31'b0, R_EN}, 32'd0);
        chk("calc_wen", {31'b0, W_EN}, 32'd0);
        chk("calc_done", {31'b0, upd_done}, 32'd0);
        n++;
        tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            n++;
            chk("wr_wen", {31'b0, W_EN}, 32'd1);
            chk("wr_ren", {31'b0, R_EN}, 32'd0);
            chk("wr_data", W_DATA, {24'b0, e});
            chk("wr_rdy", {31'b0, upd_ready}, 32'd0);
            chk("wr_done", {31'b0, upd_done}, (i == 1) ? 32'd1 : 32'd0);
            if (i == 1) begin
                chk("upd_weight", {24'b0, upd_weight}, {24'b0, e});
                chk("turnaround", 32'(n), 32'd6);
            end
            tick();
        end
        #1;
        chk("back_idle", {31'b0, busy}, 32'd0);
        chk("done_pulse", {31'b0, upd_done}, 32'd0);
        chk("idle_wen", {31'b0, W_EN}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        wen_cnt    = 0;
        loading    = 1'b0;
        cur_addr   = 16'd0;
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = 32'd0;
        upd_valid  = 1'b1;
        upd_addr   = 7'd5;
        upd_ltp    = 1'b1;
        upd_delta  = 8'd20;
        weight_in  = 8'd0;
        #3;
        chk("rst_lrdy", {31'b0, load_ready}, 32'd0);
        chk("rst_syn", {31'b0, syn_load}, 32'd0);
        chk("rst_done", {31'b0, load_done}, 32'd0);
        chk("rst_wen", {31'b0, W_EN}, 32'd0);
        chk("rst_ren", {31'b0, R_EN}, 32'd0);
        chk("rst_urdy", {31'b0, upd_ready}, 32'd0);
        chk("rst_iaddr", {16'b0, iADDR}, 32'd0);
        chk("rst_wdata", W_DATA, 32'd0);
        chk("rst_weight", {24'b0, upd_weight}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("pre_edge_lrdy", {31'b0, load_ready}, 32'd0);
        tick();
        chk("edge_lrdy", {31'b0, load_ready}, 32'd1);
        chk("edge_syn", {31'b0, syn_load}, 32'd1);

        load_table(1'b1);
        do_update(7'd5, 1'b1, 8'd20, 8'd100, 8'd120, 1'b0);
        do_update(7'd33, 1'b1, 8'd10, 8'd250, 8'd255, 1'b0);
        do_update(7'd127, 1'b0, 8'd9, 8'd3, 8'd0, 1'b1);
        do_update(7'd127, 1'b0, 8'd9, 8'd3, 8'd0, 1'b0);
        do_update(7'd64, 1'b0, 8'd0, 8'd77, 8'd77, 1'b0);
        do_update(7'd1, 1'b1, 8'd55, 8'd200, 8'd255, 1'b0);
        do_update(7'd10, 1'b0, 8'd5, 8'd50, 8'd45, 1'b0);

        cur_addr  = 16'd42;
        upd_valid = 1'b1;
        upd_addr  = 7'd42;
        upd_ltp   = 1'b1;
        upd_delta = 8'd1;
        weight_in = 8'd9;
        tick();
        upd_valid = 1'b0;
        repeat (3) tick();
        #1;
        chk("wr_pre_rst", {31'b0, W_EN}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_wen", {31'b0, W_EN}, 32'd0);
        chk("mid_rst_ren", {31'b0, R_EN}, 32'd0);
        chk("mid_rst_done", {31'b0, load_done}, 32'd0);
        chk("mid_rst_syn", {31'b0, syn_load}, 32'd0);
        chk("mid_rst_lrdy", {31'b0, load_ready}, 32'd0);
        chk("mid_rst_urdy", {31'b0, upd_ready}, 32'd0);
        chk("mid_rst_udone", {31'b0, upd_done}, 32'd0);
        chk("mid_rst_iaddr", {16'b0, iADDR}, 32'd0);
        chk("mid_rst_wdata", W_DATA, 32'd0);
        chk("mid_rst_weight", {24'b0, upd_weight}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("re_pre_lrdy", {31'b0, load_ready}, 32'd0);
        tick();
        chk("re_lrdy", {31'b0, load_ready}, 32'd1);
        chk("re_syn", {31'b0, syn_load}, 32'd1);
        upd_valid = 1'b1;
        upd_addr  = 7'd20;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("reload_urdy", {31'b0, upd_ready}, 32'd0);
            tick();
        end
        load_table(1'b0);
        do_update(7'd20, 1'b0, 8'd5, 8'd50, 8'd45, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/synapse_ctrl.md
SYNAPSE_CTRL -- requirements
Module: synapse_ctrl

Interface
REQ-001 The block SHALL have exactly one clock (clk) and one asynchronous, active-high reset (rst); the reset polarity and synchronicity are fixed.
REQ-002 Parameters (name, default, meaning) SHALL be:
- N_WORDS, 32, number of 32-bit table words loaded at start-up.
- RD_LAT, 2, cycles R_EN is held before weight_in is sampled.
- WR_HOLD, 2, cycles W_EN is held per byte write.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, clock.
- rst, in, 1, async reset, active high.
- load_valid, in, 1, host word valid.
- load_data, in, 32, host table word.
- load_ready, out, 1, word accepted this cycle when load_valid is also high.
- load_done, out, 1, table load complete (level).
- upd_valid, in, 1, STDP update request.
- upd_ready, out, 1, request accepted this cycle when upd_valid is also high.
- upd_addr, in, 7, synapse byte index 0..127.
- upd_ltp, in, 1, 1 = potentiate, 0 = depress.
- upd_delta, in, 8, magnitude of the weight change.
- upd_done, out, 1, one-cycle pulse when the write-back finishes.
- upd_weight, out, 8, new weight, valid while upd_done is high.
- syn_load, out, 1, synapse table-load mode (high only in LOAD).
- iADDR, out, 16, synapse byte address.
- W_DATA, out, 32, synapse write data.
- W_EN, out, 1, synapse write enable.
- R_EN, out, 1, synapse read enable.
- weight_in, in, 8, synapse weight read-back.
- busy, out, 1, high in every state except IDLE.

Function
REQ-004 The FSM SHALL have states LOAD, IDLE, RD, CALC and WR; it SHALL enter LOAD on reset.
REQ-005 In LOAD:
- load_ready = 1 and syn_load = 1.
- Each accepted beat SHALL drive W_EN = 1 and W_DATA = load_data for that one cycle, then increment a 5-bit word counter.
- On the N_WORDS-th accepted beat the FSM SHALL go to IDLE and set load_done = 1.
- With load_valid low, W_EN = 0 and the counter holds.
REQ-006 load_done SHALL stay 1 until reset; load_ready SHALL be 0 outside LOAD.
REQ-007 In IDLE, upd_ready SHALL be 1; an accepted request SHALL latch addr, ltp and delta and move to RD on the next cycle; upd_ready SHALL be 0 in all other states.
REQ-008 In RD:
- iADDR = {9'b0, addr} and R_EN = 1, W_EN = 0, for exactly RD_LAT cycles.
- weight_in SHALL be sampled on the last RD cycle.
- The FSM then goes to CALC.
REQ-009 In CALC (one cycle), the new weight SHALL be computed with 9-bit arithmetic and saturation:
- ltp = 1: new = min(w + delta, 255).
- ltp = 0: new = max(w - delta, 0).
- delta = 0 leaves the weight unchanged but still performs the write.
REQ-010 In WR:
- iADDR = addr, W_EN = 1, R_EN = 0, W_DATA = {24'b0, new}, for exactly WR_HOLD cycles.
- On the last WR cycle upd_done = 1 and upd_weight = new.
- The FSM then returns to IDLE.
REQ-011 R_EN and W_EN SHALL never be high in the same cycle; iADDR SHALL stay stable from RD entry to WR exit.
REQ-012 Outside RD and WR, R_EN = 0; W_EN SHALL be 0 except as specified for LOAD and WR.
REQ-013 upd_valid asserted during LOAD or while busy SHALL be ignored (not queued); the requester holds it until upd_ready.
REQ-014 A request presented in the cycle the FSM returns to IDLE SHALL be accepted on the following cycle (no back-to-back acceptance with upd_done).
REQ-015 The minimum update turnaround SHALL be 1 + RD_LAT + 1 + WR_HOLD cycles (6 at defaults) from acceptance to the upd_done cycle inclusive.

Reset
REQ-016 rst asserted at any time, including mid-LOAD or mid-update, SHALL immediately force:
- state LOAD, word counter 0, load_done 0;
- R_EN, W_EN, syn_load, upd_ready, upd_done, load_ready all 0;
- iADDR, W_DATA, upd_weight all 0.
Any in-flight write SHALL be abandoned.
REQ-017 After rst deasserts, syn_load and load_ready SHALL rise on the first clk edge.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Load 32 words, load_valid with gaps -> exactly 32 W_EN pulses, load_done = 1 after the 32nd beat, then upd_ready = 1.
- LTP at addr 5, weight_in = 100, delta = 20 -> R_EN 2 cycles at iADDR 5, then W_EN 2 cycles with W_DATA = 0x00000078; upd_done with upd_weight = 120; 6 cycles total.
- LTP at weight_in = 250, delta = 10 -> upd_weight = 255; LTD at weight_in = 3, delta = 9 -> upd_weight = 0.
- upd_valid held high during LOAD and during RD -> no acceptance until IDLE; a request held through upd_done is accepted one cycle later.
- rst pulsed during WR -> W_EN = 0 immediately, load_done = 0, LOAD re-entered; a full reload is required before the next update.
- Every cycle -> R_EN and W_EN are never both 1, and iADDR is stable throughout each update.
